ysyx_23060229_mem_arbiter: RTL and testbench

//  Shares the single memory port between the instruction-fetch unit (IFU) and the

---
 rtl/ysyx_23060229_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ysyx_23060229_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060229_mem_arbiter.sv
// Memory-port arbiter: shares one memory port between the IFU and the LSU.
// LSU wins ties unless the IFU has been passed over STREAK_MAX times in a row.
module ysyx_23060229_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [7:0]            lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp_valid
);

    localparam int unsigned StreakW = $clog2(STREAK_MAX + 1);
    localparam logic [StreakW-1:0] StreakTop = StreakW'(STREAK_MAX);

    typedef enum logic [1:0] {StIdle, StIfuBusy, StLsuBusy} state_e;

    state_e                state_q, state_d;
    logic [StreakW-1:0]    streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wmask_q, wmask_d;
    logic                  ren_q, ren_d;
    logic                  wen_q, wen_d;
    logic                  ifu_resp_q, ifu_resp_d;
    logic                  lsu_resp_q, lsu_resp_d;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
    logic                  grant_ifu, grant_lsu;

    // Combinational grant in IDLE; masked during reset so every output reads 0.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (lsu_req_valid && !(ifu_req_valid && streak_q == StreakTop)) begin
                grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
                grant_ifu = 1'b1;
            end
        end
    end

    // Next-state: capture the granted request, hold the strobe until memory completes.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        ifu_resp_d  = 1'b0;
        lsu_resp_d  = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_lsu) begin
                    state_d = StLsuBusy;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    wen_d   = lsu_wen;
                    ren_d   = !lsu_wen;
                    // Count only grants that made a waiting IFU lose out.
                    if (!ifu_req_valid) begin
                        streak_d = '0;
                    end else if (streak_q != StreakTop) begin
                        streak_d = streak_q + StreakW'(1);
                    end
                end else if (grant_ifu) begin
                    state_d  = StIfuBusy;
                    addr_d   = ifu_addr;
                    wen_d    = 1'b0;
                    ren_d    = 1'b1;
                    streak_d = '0;
                end else if (!ifu_req_valid) begin
                    streak_d = '0;
                end
            end
            StIfuBusy: begin
                if (mem_resp_valid) begin
                    state_d     = StIdle;
                    ren_d       = 1'b0;
                    ifu_resp_d  = 1'b1;
                    ifu_rdata_d = mem_rdata;
                end
            end
            StLsuBusy: begin
                if (mem_resp_valid) begin
                    state_d     = StIdle;
                    ren_d       = 1'b0;
                    wen_d       = 1'b0;
                    lsu_resp_d  = 1'b1;
                    lsu_rdata_d = wen_q ? '0 : mem_rdata;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; async reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            streak_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = ifu_resp_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign mem_ren        = ren_q;
    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

endmodule

// File: tb/tb_ysyx_23060229_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: vector table of single accesses plus
// hand-written sequences for priority, streak, reset abort and idle responses.
module tb_ysyx_23060229_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask, mem_wmask;
    logic        mem_ren, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ifu_rd, exp_lsu_rd;

    typedef struct packed {
        logic        is_lsu;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int unsigned wait_cyc;
        logic [31:0] mem_rd;
        logic [31:0] exp_rd;
        int unsigned exp_strobes;
    } txn_t;

    txn_t vec [5];

    ysyx_23060229_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STREAK_MAX(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_wen       (lsu_wen),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rdata     (mem_rdata),
        .mem_resp_valid(mem_resp_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ifu_ready"}, 32'(ifu_req_ready), 32'h0);
        chk({tag, "_lsu_ready"}, 32'(lsu_req_ready), 32'h0);
        chk({tag, "_ifu_resp"}, 32'(ifu_resp_valid), 32'h0);
        chk({tag, "_lsu_resp"}, 32'(lsu_resp_valid), 32'h0);
        chk({tag, "_ifu_rdata"}, ifu_rdata, 32'h0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
        chk({tag, "_mem_ren"}, 32'(mem_ren), 32'h0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
    endtask

    // One complete access; entered and left just after a rising edge in IDLE.
    task automatic do_txn(input txn_t t);
        int unsigned strobes = 0;
        int unsigned wrong = 0;
        logic        right_s, wrong_s;
        ifu_req_valid = !t.is_lsu;
        lsu_req_valid = t.is_lsu;
        ifu_addr      = t.addr;
        lsu_addr      = t.addr;
        lsu_wen       = t.wen;
        lsu_wdata     = t.wdata;
        lsu_wmask     = t.wmask;
        @(negedge clk);
        if (t.is_lsu) begin
            chk("txn_lsu_ready", 32'(lsu_req_ready), 32'h1);
            chk("txn_ifu_ready_excl", 32'(ifu_req_ready), 32'h0);
        end else begin
            chk("txn_ifu_ready", 32'(ifu_req_ready), 32'h1);
            chk("txn_lsu_ready_excl", 32'(lsu_req_ready), 32'h0);
        end
        step();
        // Scramble request inputs so only registered values can reach memory.
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        ifu_addr      = 32'hFFFF_FFFF;
        lsu_addr      = 32'hFFFF_FFFF;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 8'h0;
        lsu_wen       = !t.wen;
        for (int unsigned k = 0; k <= t.wait_cyc; k++) begin
            mem_resp_valid = (k == t.wait_cyc);
            mem_rdata      = (k == t.wait_cyc) ? t.mem_rd : 32'h5555_5555;
            @(negedge clk);
            right_s = (t.is_lsu && t.wen) ? mem_wen : mem_ren;
            wrong_s = (t.is_lsu && t.wen) ? mem_ren : mem_wen;
            if (right_s) strobes++;
            if (wrong_s) wrong++;
            if (k == 0) begin
                chk("txn_mem_addr", mem_addr, t.addr);
                if (t.is_lsu && t.wen) begin
                    chk("txn_mem_wdata", mem_wdata, t.wdata);
                    chk("txn_mem_wmask", 32'(mem_wmask), 32'(t.wmask));
                end
            end
            step();
        end
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h7777_7777;
        chk("txn_strobe_cycles", strobes, t.exp_strobes);
        chk("txn_wrong_strobe", wrong, 32'h0);
        if (t.is_lsu) exp_lsu_rd = t.exp_rd;
        else exp_ifu_rd = t.exp_rd;
        @(negedge clk);
        chk("txn_ifu_resp", 32'(ifu_resp_valid), 32'(!t.is_lsu));
        chk("txn_lsu_resp", 32'(lsu_resp_valid), 32'(t.is_lsu));
        chk("txn_ifu_rdata", ifu_rdata, exp_ifu_rd);
        chk("txn_lsu_rdata", lsu_rdata, exp_lsu_rd);
        chk("txn_strobe_off", 32'(mem_ren | mem_wen), 32'h0);
        step();
        @(negedge clk);
        chk("txn_pulse_end", 32'(ifu_resp_valid | lsu_resp_valid), 32'h0);
        step();
    endtask

    logic is_ifu_grant [6];
    logic exp_pat [6];
    int   ngrant;
    int   both;

    initial begin
        vec[0] = '{is_lsu: 1'b0, wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00,
                   wait_cyc: 0, mem_rd: 32'h0000_0413, exp_rd: 32'h0000_0413, exp_strobes: 1};
        vec[1] = '{is_lsu: 1'b1, wen: 1'b1, addr: 32'h8000_0100, wdata: 32'hDEAD_BEEF,
                   wmask: 8'h0F, wait_cyc: 2, mem_rd: 32'h1234_5678, exp_rd: 32'h0,
                   exp_strobes: 3};
        vec[2] = '{is_lsu: 1'b1, wen: 1'b0, addr: 32'h8000_0200, wdata: 32'h0, wmask: 8'h00,
                   wait_cyc: 1, mem_rd: 32'hCAFE_F00D, exp_rd: 32'hCAFE_F00D, exp_strobes: 2};
        vec[3] = '{is_lsu: 1'b0, wen: 1'b0, addr: 32'h8000_0004, wdata: 32'h0, wmask: 8'h00,
                   wait_cyc: 3, mem_rd: 32'h0010_0093, exp_rd: 32'h0010_0093, exp_strobes: 4};
        vec[4] = '{is_lsu: 1'b1, wen: 1'b0, addr: 32'h8000_0300, wdata: 32'h0, wmask: 8'h00,
                   wait_cyc: 0, mem_rd: 32'hA5A5_A5A5, exp_rd: 32'hA5A5_A5A5, exp_strobes: 1};
        exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        ifu_addr = 32'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 8'h0;
        mem_rdata = 32'h0; mem_resp_valid = 1'b0;
        exp_ifu_rd = 32'h0; exp_lsu_rd = 32'h0;
        step();
        step();
        @(negedge clk);
        check_zero("reset");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) do_txn(vec[i]);

        // Simultaneous requests with streak 0: LSU first, IFU on the next IDLE cycle.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        ifu_addr = 32'h8000_0040; lsu_addr = 32'h8000_0400;
        @(negedge clk);
        chk("tie_lsu_ready", 32'(lsu_req_ready), 32'h1);
        chk("tie_ifu_ready", 32'(ifu_req_ready), 32'h0);
        step();
        lsu_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        chk("tie_busy_ifu_ready", 32'(ifu_req_ready), 32'h0);
        step();
        mem_rdata = 32'h5555_6666;
        @(negedge clk);
        chk("tie_ifu_ready_next", 32'(ifu_req_ready), 32'h1);
        chk("tie_lsu_resp", 32'(lsu_resp_valid), 32'h1);
        chk("tie_lsu_rdata", lsu_rdata, 32'h3333_4444);
        step();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("tie_ifu_ren", 32'(mem_ren), 32'h1);
        chk("tie_ifu_addr", mem_addr, 32'h8000_0040);
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("tie_ifu_resp", 32'(ifu_resp_valid), 32'h1);
        chk("tie_ifu_rdata", ifu_rdata, 32'h5555_6666);
        exp_ifu_rd = 32'h5555_6666; exp_lsu_rd = 32'h3333_4444;
        step();
        step();

        // Both requesters held with zero-wait memory: expect L,L,L,L,I,L.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        ngrant = 0; both = 0;
        for (int c = 0; c < 40 && ngrant < 6; c++) begin
            @(negedge clk);
            if (ifu_req_ready && lsu_req_ready) both++;
            if (ifu_req_ready || lsu_req_ready) begin
                is_ifu_grant[ngrant] = ifu_req_ready;
                ngrant++;
            end
            step();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("streak_grant_count", 32'(ngrant), 32'd6);
        chk("streak_both_ready", 32'(both), 32'h0);
        for (int g = 0; g < 6; g++) begin
            if (g < ngrant) chk($sformatf("streak_grant%0d", g), 32'(is_ifu_grant[g]),
                                32'(exp_pat[g]));
        end
        step();
        mem_resp_valid = 1'b0;
        step();
        step();
        exp_ifu_rd = 32'h1111_2222; exp_lsu_rd = 32'h1111_2222;

        // Reset in the second LSU_BUSY cycle, then a late memory response.
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0500;
        step();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_ren", 32'(mem_ren), 32'h1);
        step();
        rst = 1'b1; ifu_req_valid = 1'b1;
        #1;
        check_zero("abort_async");
        @(negedge clk);
        check_zero("abort_held");
        step();
        rst = 1'b0; ifu_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        chk("abort_late_resp", 32'(lsu_resp_valid), 32'h0);
        chk("abort_late_ren", 32'(mem_ren), 32'h0);
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("abort_late_resp2", 32'(lsu_resp_valid), 32'h0);
        chk("abort_lsu_rdata", lsu_rdata, 32'h0);
        exp_ifu_rd = 32'h0; exp_lsu_rd = 32'h0;
        step();
        do_txn(vec[2]);

        // Memory response while IDLE with no requests must be ignored.
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_ifu_resp", 32'(ifu_resp_valid), 32'h0);
            chk("idle_lsu_resp", 32'(lsu_resp_valid), 32'h0);
            chk("idle_ifu_rdata", ifu_rdata, exp_ifu_rd);
            chk("idle_strobe", 32'(mem_ren | mem_wen), 32'h0);
            step();
        end
        mem_resp_valid = 1'b0;
        do_txn(vec[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
